// File: rtl/rsa_pkg.sv
// Shared definitions for the Montgomery modular exponentiation block:
// operand/accumulator widths, the per-multiply cycle count and the FSM states.
package rsa_pkg;

    localparam int OP_W      = 8;
    localparam int ACC_W     = OP_W + 2;
    // One Montgomery multiply: OP_W iteration cycles plus one correction cycle
    localparam int MM_CYCLES = OP_W + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        PRE_M = 3'd2,
        PRE_X = 3'd3,
        SQR   = 3'd4,
        MUL   = 3'd5,
        POST  = 3'd6,
        DONE  = 3'd7
    } state_t;

endpackage

// File: rtl/rsa_mont_mul.sv
// Radix-2 bit-serial Montgomery multiplier, p = a*b*2^-W mod n.
// go latches the operands; ready is high during the final correction cycle,
// exactly W+1 cycles after the go edge, with the reduced product on p.
module rsa_mont_mul
    import rsa_pkg::*;
#(
    parameter int W = OP_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         go,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    output logic         ready,
    output logic [W-1:0] p
);

    // Two guard bits: acc stays below 2n and acc + b + n stays below 4n
    localparam int AW = W + 2;
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  n_q;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          active;

    logic [AW-1:0] sum_b;
    logic [AW-1:0] sum_n;
    logic [AW-1:0] acc_nxt;
    logic [AW-1:0] acc_sub;

    // One iteration step and the final conditional subtraction
    always_comb begin
        sum_b   = acc + ({AW{a_q[0]}} & {2'b00, b_q});
        sum_n   = sum_b + ({AW{sum_b[0]}} & {2'b00, n_q});
        acc_nxt = sum_n >> 1;
        acc_sub = acc - {2'b00, n_q};
        p       = (acc >= {2'b00, n_q}) ? acc_sub[W-1:0] : acc[W-1:0];
        ready   = active && (cnt == CW'(W));
    end

    // Operand capture, W iteration cycles, then one correction cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            n_q    <= '0;
            acc    <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (go) begin
            a_q    <= a;
            b_q    <= b;
            n_q    <= n;
            acc    <= '0;
            cnt    <= '0;
            active <= 1'b1;
        end else if (active) begin
            if (cnt != CW'(W)) begin
                acc <= acc_nxt;
                a_q <= a_q >> 1;
                cnt <= cnt + CW'(1);
            end else begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rsa_mont_exp.sv
// Modular exponentiation C = M^E mod N using left-to-right square-and-multiply
// in the Montgomery domain, with one shared bit-serial Montgomery multiplier.
// Each multiply's result is forwarded straight into the next multiply so that
// consecutive multiplies run back to back.
// Optional feature: define RSA_MOD_CHECK_EN to reject even moduli or N < 3
// (err set, result forced to 0); otherwise err is tied low.
module rsa_mont_exp
    import rsa_pkg::*;
#(
    parameter int W = OP_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         stop,
    input  logic [W-1:0] plain_text,
    input  logic [W-1:0] exponent,
    input  logic [W-1:0] modulus,
    input  logic [W-1:0] mont_const,
    output logic [W-1:0] result,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int IW = $clog2(W);
    localparam logic [W-1:0] ONE_W = W'(1);

    state_t        state;
    logic [W-1:0]  m_q;
    logic [W-1:0]  e_q;
    logic [W-1:0]  n_q;
    logic [W-1:0]  r2_q;
    logic [W-1:0]  mbar;
    logic [IW-1:0] bit_idx;

    logic          mm_go;
    logic [W-1:0]  mm_a;
    logic [W-1:0]  mm_b;
    logic          mm_ready;
    logic [W-1:0]  mm_p;

`ifdef RSA_MOD_CHECK_EN
    logic          err_q;
    logic          mod_bad;

    assign mod_bad = !n_q[0] || (n_q < W'(3));
    assign err     = err_q;
`else
    assign err     = 1'b0;
`endif

    assign busy = (state != IDLE) && (state != DONE);

    rsa_mont_mul #(.W(W)) u_mm (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (mm_go),
        .a     (mm_a),
        .b     (mm_b),
        .n     (n_q),
        .ready (mm_ready),
        .p     (mm_p)
    );

    // Launch the next multiply on the edge the current one completes
    always_comb begin
        mm_go = 1'b0;
        mm_a  = mm_p;
        mm_b  = mm_p;
        case (state)
            LOAD: begin
`ifdef RSA_MOD_CHECK_EN
                if (!mod_bad) begin
                    mm_go = 1'b1;
                    mm_a  = m_q;
                    mm_b  = r2_q;
                end
`else
                mm_go = 1'b1;
                mm_a  = m_q;
                mm_b  = r2_q;
`endif
            end
            PRE_M: begin
                mm_go = mm_ready;
                mm_a  = ONE_W;
                mm_b  = r2_q;
            end
            PRE_X: begin
                mm_go = mm_ready;
            end
            SQR: begin
                mm_go = mm_ready;
                if (e_q[bit_idx]) begin
                    mm_a = mbar;
                end else if (bit_idx == '0) begin
                    mm_b = ONE_W;
                end
            end
            MUL: begin
                mm_go = mm_ready;
                if (bit_idx == '0) begin
                    mm_b = ONE_W;
                end
            end
            default: begin
                mm_go = 1'b0;
            end
        endcase
    end

    // Control FSM, operand capture and result/flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            m_q     <= '0;
            e_q     <= '0;
            n_q     <= '0;
            r2_q    <= '0;
            mbar    <= '0;
            bit_idx <= '0;
            result  <= '0;
            done    <= 1'b0;
`ifdef RSA_MOD_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else if (stop) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        m_q     <= plain_text;
                        e_q     <= exponent;
                        n_q     <= modulus;
                        r2_q    <= mont_const;
                        bit_idx <= IW'(W - 1);
                        done    <= 1'b0;
`ifdef RSA_MOD_CHECK_EN
                        err_q   <= 1'b0;
`endif
                        state   <= LOAD;
                    end
                end
                LOAD: begin
`ifdef RSA_MOD_CHECK_EN
                    // A bad modulus flags err first, then lands in DONE a cycle later
                    if (mod_bad) begin
                        if (err_q) begin
                            result <= '0;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            err_q  <= 1'b1;
                        end
                    end else begin
                        state <= PRE_M;
                    end
`else
                    state <= PRE_M;
`endif
                end
                PRE_M: begin
                    if (mm_ready) begin
                        mbar  <= mm_p;
                        state <= PRE_X;
                    end
                end
                PRE_X: begin
                    if (mm_ready) begin
                        state <= SQR;
                    end
                end
                SQR: begin
                    if (mm_ready) begin
                        if (e_q[bit_idx]) begin
                            state <= MUL;
                        end else if (bit_idx == '0) begin
                            state <= POST;
                        end else begin
                            bit_idx <= bit_idx - IW'(1);
                        end
                    end
                end
                MUL: begin
                    if (mm_ready) begin
                        if (bit_idx == '0) begin
                            state <= POST;
                        end else begin
                            bit_idx <= bit_idx - IW'(1);
                            state   <= SQR;
                        end
                    end
                end
                POST: begin
                    if (mm_ready) begin
                        result <= mm_p;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_mont_exp.sv
// Directed bench for rsa_mont_exp (W=8). Cycle k is the sample taken 1 time
// unit after the k-th rising edge following the edge that accepted start.
module tb_rsa_mont_exp;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [7:0] plain_text;
    logic [7:0] exponent;
    logic [7:0] modulus;
    logic [7:0] mont_const;
    logic [7:0] result;
    logic       busy;
    logic       done;
    logic       err;

    int total = 0;
    int bad   = 0;

    rsa_mont_exp #(.W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .plain_text (plain_text),
        .exponent   (exponent),
        .modulus    (modulus),
        .mont_const (mont_const),
        .result     (result),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands with start for one edge; returns at cycle 0
    task automatic do_start(input logic [7:0] m, input logic [7:0] e,
                            input logic [7:0] n, input logic [7:0] r2);
        plain_text = m;
        exponent   = e;
        modulus    = n;
        mont_const = r2;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
    endtask

    // Wait (bounded) for done; busy must stay high and done low until then.
    // With disturb set, start is held and operands are scrambled mid-run.
    task automatic run_op(input string tag, input int exp_cyc, input logic [7:0] exp_res,
                          input bit chk_res, input bit disturb);
        int cyc;
        bit ok;
        cyc = 0;
        ok  = 1'b1;
        while (done !== 1'b1 && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done !== 1'b1 && busy !== 1'b1) ok = 1'b0;
            if (disturb && cyc == 10) begin
                start      = 1'b1;
                plain_text = 8'hFF;
                exponent   = 8'hFF;
                modulus    = 8'h05;
                mont_const = 8'h01;
            end
            if (disturb && cyc == 100) start = 1'b0;
        end
        check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_busy_run"}, 32'(ok), 32'd1);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        if (chk_res) check({tag, "_result"}, 32'(result), 32'(exp_res));
        @(posedge clk);
        #1;
        check({tag, "_done_sticky"}, 32'(done), 32'd1);
        if (chk_res) check({tag, "_result_hold"}, 32'(result), 32'(exp_res));
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        plain_text = 8'h00;
        exponent   = 8'h00;
        modulus    = 8'h00;
        mont_const = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", 32'(result), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 0x58^7 mod 187 = 0x0B, popcount 3 -> 1 + 9*14 = 127
        do_start(8'h58, 8'h07, 8'hBB, 8'h56);
        check("enc_busy_c0", 32'(busy), 32'd1);
        run_op("enc", 127, 8'h0B, 1'b1, 1'b0);
        check("enc_err", 32'(err), 32'd0);

        // 0x0B^0x17 mod 187 = 0x58, popcount 4 -> 136
        do_start(8'h0B, 8'h17, 8'hBB, 8'h56);
        run_op("dec", 136, 8'h58, 1'b1, 1'b0);

        // E = 0 -> 1 after 100 cycles
        do_start(8'h33, 8'h00, 8'hBB, 8'h56);
        run_op("e0", 100, 8'h01, 1'b1, 1'b0);

        // stop sampled at cycle 50 -> idle, result keeps 0x01
        do_start(8'h58, 8'h07, 8'hBB, 8'h56);
        repeat (49) @(posedge clk);
        #1;
        check("stop_busy_c49", 32'(busy), 32'd1);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_done", 32'(done), 32'd0);
        check("stop_result", 32'(result), 32'h01);
        repeat (3) @(posedge clk);
        #1;
        check("stop_stays_idle", 32'(busy), 32'd0);

        // fresh start after stop
        do_start(8'h58, 8'h07, 8'hBB, 8'h56);
        run_op("restart", 127, 8'h0B, 1'b1, 1'b0);

        // start and stop together from DONE: stop wins
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        check("ss_busy", 32'(busy), 32'd0);
        check("ss_done", 32'(done), 32'd0);
        check("ss_result", 32'(result), 32'h0B);
        @(posedge clk);
        #1;
        check("ss_busy_after", 32'(busy), 32'd0);

        // start held while busy and operands scrambled mid-run
        do_start(8'h58, 8'h07, 8'hBB, 8'h56);
        run_op("disturb", 127, 8'h0B, 1'b1, 1'b1);

        // Invalid (even) modulus
        do_start(8'h58, 8'h07, 8'hBC, 8'h56);
`ifdef RSA_MOD_CHECK_EN
        @(posedge clk);
        #1;
        check("badn_done_c1", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        check("badn_done_c2", 32'(done), 32'd1);
        check("badn_err", 32'(err), 32'd1);
        check("badn_result", 32'(result), 32'd0);
        check("badn_busy", 32'(busy), 32'd0);
`else
        run_op("badn", 127, 8'h00, 1'b0, 1'b0);
        check("badn_err", 32'(err), 32'd0);
`endif

        // next accepted start clears err
        do_start(8'h9A, 8'h00, 8'hBB, 8'h56);
        check("clr_err", 32'(err), 32'd0);
        run_op("e0b", 100, 8'h01, 1'b1, 1'b0);

        // Reset mid-operation
        do_start(8'h58, 8'h07, 8'hBB, 8'h56);
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_result", 32'(result), 32'd0);
        check("mrst_err", 32'(err), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("mrst_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
